// File: rtl/qsram_pkg.sv
// qsram_pkg: shared types, width helper and cell-level width constants for the QSRAM models
package qsram_pkg;
  localparam int QSRAM_DATA_WIDTH = 8;
  localparam int QSRAM_DEPTH = 16;
  typedef enum logic [1:0] {IDLE, SENSE, RESTORE} refresh_state_t;
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/qsram_row_age.sv
// qsram_row_age: saturating age counter for one row; decay_o pulses on the edge the age reaches RetentionLimit
// ports: clk_i clock, rst_i sync reset, clr_i row written/restored this cycle, decay_o row loses its data now
module qsram_row_age #(
  parameter int RetentionLimit = 2048
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic decay_o
);
  localparam int AgeWidth = $clog2(RetentionLimit + 1);
  logic [AgeWidth-1:0] age_q, age_d;
  assign decay_o = !rst_i && !clr_i && age_q == AgeWidth'(RetentionLimit - 1);
  always_comb age_d = clr_i ? '0 : (age_q == AgeWidth'(RetentionLimit)) ? age_q : age_q + 1'b1;
  always_ff @(posedge clk_i) age_q <= rst_i ? '0 : age_d;
endmodule

// File: rtl/qsram_array_refresh.sv
// qsram_array_refresh: decaying RAM array with a sense/restore refresh scheduler and lost-row tracking
// ports: addr_i/wr_req_i/wr_data_i/rd_req_i user request, ready_o request accepted, rd_data_o/rd_valid_o read result,
//        refresh_active_o in SENSE/RESTORE, data_lost_o sticky loss flag, lost_row_o first decayed row
module qsram_array_refresh
  import qsram_pkg::*;
#(
  parameter int DataWidth       = 8,
  parameter int Depth           = 16,
  parameter int RefreshInterval = 64,
  parameter int RetentionLimit  = 2048
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [addr_width(Depth)-1:0]  addr_i,
  input  logic                          wr_req_i,
  input  logic [DataWidth-1:0]          wr_data_i,
  input  logic                          rd_req_i,
  output logic                          ready_o,
  output logic [DataWidth-1:0]          rd_data_o,
  output logic                          rd_valid_o,
  output logic                          refresh_active_o,
  output logic                          data_lost_o,
  output logic [addr_width(Depth)-1:0]  lost_row_o
);
  localparam int AddrWidth = addr_width(Depth);
  localparam int CntWidth = addr_width(RefreshInterval);
  refresh_state_t state_q, state_d;
  logic [CntWidth-1:0] cnt_q;
  logic [AddrWidth-1:0] row_q, lost_row_q, lost_row_d;
  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] sense_q, rd_data_q;
  logic rd_valid_q, lost_q;
  logic [Depth-1:0] clr, decay;
  logic wr_acc, rd_acc, restore, start;
  assign ready_o = state_q == IDLE && !rst_i;
  assign wr_acc = ready_o && wr_req_i;
  assign rd_acc = ready_o && rd_req_i;
  assign restore = state_q == RESTORE;
  assign start = cnt_q == CntWidth'(RefreshInterval - 1);
  assign rd_data_o = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign refresh_active_o = state_q != IDLE;
  assign data_lost_o = lost_q;
  assign lost_row_o = lost_row_q;
  always_comb state_d = state_q == IDLE ? (start ? SENSE : IDLE) : state_q == SENSE ? RESTORE : IDLE;
  for (genvar g = 0; g < Depth; g++) begin : g_age
    assign clr[g] = (wr_acc && addr_i == AddrWidth'(g)) || (restore && row_q == AddrWidth'(g));
    qsram_row_age #(.RetentionLimit(RetentionLimit)) u_age (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (clr[g]),
      .decay_o(decay[g])
    );
  end
  always_comb begin
    lost_row_d = '0;
    for (int i = Depth - 1; i >= 0; i--) if (decay[i]) lost_row_d = AddrWidth'(i);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      sense_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      lost_q     <= 1'b0;
      lost_row_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= start ? '0 : cnt_q + 1'b1;
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem_q[addr_i];
      if (state_q == SENSE) sense_q <= mem_q[row_q];
      if (restore) row_q <= (row_q == AddrWidth'(Depth - 1)) ? '0 : row_q + 1'b1;
      if (!lost_q && |decay) begin
        lost_q     <= 1'b1;
        lost_row_q <= lost_row_d;
      end
      for (int i = 0; i < Depth; i++) begin
        if (clr[i]) mem_q[i] <= restore ? sense_q : wr_data_i;
        else if (decay[i]) mem_q[i] <= '0;
      end
    end
  end
endmodule
